// File: rtl/imem_boot_ctrl_if.sv
// Boot-loader bus: host byte stream, instruction-memory write/read ports and CPU control.
// The boot controller attaches to the slave modport; whoever drives it uses master.
interface imem_boot_ctrl_if #(
    parameter int IDX_W = 8
);
    logic             load_start;
    logic [IDX_W:0]   load_len;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_waddr;
    logic [31:0]      mem_wdata;
    logic [31:0]      fetch_addr;
    logic [31:0]      mem_raddr;
    logic             cpu_rst_n;
    logic             busy;
    logic             done;
    logic             err;

    modport slave (
        input  load_start, load_len, byte_valid, byte_data, fetch_addr,
        output byte_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
               cpu_rst_n, busy, done, err
    );

    modport master (
        output load_start, load_len, byte_valid, byte_data, fetch_addr,
        input  byte_ready, mem_we, mem_waddr, mem_wdata, mem_raddr,
               cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Instruction-memory boot sequencer: holds the CPU in reset, packs a little-endian byte
// stream into 32-bit words, writes them to imem, then releases the CPU and forwards fetches.
module imem_boot_ctrl #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    imem_boot_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    localparam logic [IDX_W:0] DEPTH_W = (IDX_W+1)'(DEPTH);

    state_e           state_q, state_d;
    logic [IDX_W:0]   len_q, len_d;
    logic [IDX_W:0]   idx_q, idx_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [23:0]      asm_q, asm_d;
    logic             we_q, we_d;
    logic [31:0]      waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             cpu_run_q, cpu_run_d;
    logic             ready;
    logic             accept;

    // Stop taking bytes once every requested word has been assembled.
    assign ready  = (state_q == LOAD) && (idx_q != len_q);
    assign accept = ready && bus.byte_valid;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;

        if ((state_q != LOAD) && bus.load_start) begin
            if (bus.load_len == '0) begin
                state_d = RUN;
            end else if (bus.load_len > DEPTH_W) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                err_d   = 1'b0;
                state_d = LOAD;
                len_d   = bus.load_len;
                idx_d   = '0;
                cnt_d   = '0;
                asm_d   = '0;
            end
        end

        if (state_q == LOAD) begin
            if (accept) begin
                case (cnt_q)
                    2'd0: asm_d[7:0]   = bus.byte_data;
                    2'd1: asm_d[15:8]  = bus.byte_data;
                    2'd2: asm_d[23:16] = bus.byte_data;
                    default: begin
                        wdata_d = {bus.byte_data, asm_q};
                        waddr_d = {{(30-IDX_W){1'b0}}, idx_q[IDX_W-1:0], 2'b00};
                        we_d    = 1'b1;
                        idx_d   = idx_q + 1'b1;
                        asm_d   = '0;
                    end
                endcase
                cnt_d = cnt_q + 2'd1;
            end
            // Leave LOAD at the end of the final word's write cycle.
            if (we_q && (idx_q == len_q)) begin
                state_d = RUN;
            end
        end
    end

    assign cpu_run_d = (state_d == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            asm_q     <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cpu_run_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cpu_run_q <= cpu_run_d;
        end
    end

    assign bus.byte_ready = ready;
    assign bus.mem_we     = we_q;
    assign bus.mem_waddr  = waddr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_rst_n  = cpu_run_q;
    assign bus.busy       = (state_q == LOAD);
    assign bus.done       = (state_q == RUN);
    assign bus.err        = err_q;
    assign bus.mem_raddr  = (state_q == RUN) ? bus.fetch_addr : 32'h0;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Bench for imem_boot_ctrl: a cycle-level vector table, directed corner sequences, and
// randomized loads scored against a word-list model built from the byte stream.
module tb_imem_boot_ctrl;
    localparam int DEPTH = 256;
    localparam int IDX_W = 8;

    logic clk;
    logic rst_n;

    imem_boot_ctrl_if #(.IDX_W(IDX_W)) bus();

    imem_boot_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic             loadStart;
        logic [IDX_W:0]   loadLen;
        logic             byteValid;
        logic [7:0]       byteData;
        logic [31:0]      fetchAddr;
        logic             expReady;
        logic             expWe;
        logic [31:0]      expWaddr;
        logic [31:0]      expWdata;
        logic [31:0]      expRaddr;
        logic             expCpuRstN;
        logic             expBusy;
        logic             expDone;
        logic             expErr;
    } vec_t;

    vec_t         vecs[17];
    int           checkCount = 0;
    int           passCount  = 0;
    logic [63:0]  writeLog[$];
    logic [7:0]   progBytes[$];
    logic         modelErr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (rst_n && bus.mem_we) writeLog.push_back({bus.mem_waddr, bus.mem_wdata});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.load_start = v.loadStart;
        bus.load_len   = v.loadLen;
        bus.byte_valid = v.byteValid;
        bus.byte_data  = v.byteData;
        bus.fetch_addr = v.fetchAddr;
    endtask

    task automatic checkResetValues(input string tag);
        checkBit({tag, ".byteReady"}, bus.byte_ready, 1'b0);
        checkBit({tag, ".memWe"}, bus.mem_we, 1'b0);
        checkOutput({tag, ".memWaddr"}, bus.mem_waddr, 32'h0);
        checkOutput({tag, ".memWdata"}, bus.mem_wdata, 32'h0);
        checkOutput({tag, ".memRaddr"}, bus.mem_raddr, 32'h0);
        checkBit({tag, ".cpuRstN"}, bus.cpu_rst_n, 1'b0);
        checkBit({tag, ".busy"}, bus.busy, 1'b0);
        checkBit({tag, ".done"}, bus.done, 1'b0);
        checkBit({tag, ".err"}, bus.err, 1'b0);
    endtask

    // Issue a load request and check the state it must land in from the length rules alone.
    task automatic startLoad(input logic [IDX_W:0] len);
        logic isRun;
        logic isLoad;
        isRun  = (len == 0);
        isLoad = (len != 0) && (int'(len) <= DEPTH);
        if (int'(len) > DEPTH) modelErr = 1'b1;
        else if (len != 0) modelErr = 1'b0;
        bus.load_start = 1'b1;
        bus.load_len   = len;
        @(negedge clk);
        bus.load_start = 1'b0;
        checkBit("start.busy", bus.busy, isLoad);
        checkBit("start.done", bus.done, isRun);
        checkBit("start.cpuRstN", bus.cpu_rst_n, isRun);
        checkBit("start.byteReady", bus.byte_ready, isLoad);
        checkBit("start.err", bus.err, modelErr);
        checkBit("start.memWe", bus.mem_we, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] b);
        int guard;
        guard = 0;
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        while (!bus.byte_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkBit("byteReadyForByte", bus.byte_ready, 1'b1);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom);
    endtask

    task automatic compareWrites();
        int n;
        int m;
        n = progBytes.size() / 4;
        checkOutput("writeCount", 32'(writeLog.size()), 32'(n));
        m = (writeLog.size() < n) ? writeLog.size() : n;
        for (int w = 0; w < m; w++) begin
            checkOutput($sformatf("write%0d.addr", w), writeLog[w][63:32], 32'(w * 4));
            checkOutput($sformatf("write%0d.data", w), writeLog[w][31:0],
                        {progBytes[4*w+3], progBytes[4*w+2], progBytes[4*w+1], progBytes[4*w]});
        end
    endtask

    // mode 0: back-to-back, 1: one idle cycle between bytes, 2: random idle gaps.
    task automatic streamProgram(input int mode);
        int gaps;
        for (int i = 0; i < progBytes.size(); i++) begin
            if (mode == 0) gaps = 0;
            else if (mode == 1) gaps = (i > 0) ? 1 : 0;
            else gaps = $urandom_range(0, 2);
            repeat (gaps) @(negedge clk);
            sendByte(progBytes[i]);
            checkBit($sformatf("memWeAfterByte%0d", i), bus.mem_we, (i % 4) == 3);
        end
        @(negedge clk);
        checkBit("final.done", bus.done, 1'b1);
        checkBit("final.cpuRstN", bus.cpu_rst_n, 1'b1);
        checkBit("final.busy", bus.busy, 1'b0);
        checkBit("final.memWe", bus.mem_we, 1'b0);
        compareWrites();
    endtask

    initial begin
        logic [IDX_W:0] len;
        int             sel;
        logic [31:0]    fa;

        vecs[0]  = '{1'b1, 9'd2, 1'b0, 8'h00, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h0,        32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 9'd2, 1'b1, 8'h93, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h0,        32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 9'd2, 1'b1, 8'h01, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h0,        32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 9'd2, 1'b1, 8'h10, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h0,        32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 9'd2, 1'b1, 8'h00, 32'h1C, 1'b1, 1'b1, 32'h0, 32'h00100193, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 9'd2, 1'b1, 8'h33, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h00100193, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 9'd2, 1'b1, 8'h82, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h00100193, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 9'd2, 1'b1, 8'h20, 32'h1C, 1'b1, 1'b0, 32'h0, 32'h00100193, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 9'd2, 1'b1, 8'h00, 32'h1C, 1'b0, 1'b1, 32'h4, 32'h00208233, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 9'd2, 1'b0, 8'hAA, 32'h1C, 1'b0, 1'b0, 32'h4, 32'h00208233, 32'h1C, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 9'd2, 1'b1, 8'h55, 32'h40, 1'b0, 1'b0, 32'h4, 32'h00208233, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 9'd1, 1'b0, 8'h00, 32'h40, 1'b1, 1'b0, 32'h4, 32'h00208233, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 9'd0, 1'b1, 8'h13, 32'h40, 1'b1, 1'b0, 32'h4, 32'h00208233, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 9'd0, 1'b1, 8'h00, 32'h40, 1'b1, 1'b0, 32'h4, 32'h00208233, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 9'd0, 1'b1, 8'h00, 32'h40, 1'b1, 1'b0, 32'h4, 32'h00208233, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 9'd0, 1'b1, 8'h00, 32'h40, 1'b0, 1'b1, 32'h0, 32'h00000013, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 9'd0, 1'b0, 8'h00, 32'h40, 1'b0, 1'b0, 32'h0, 32'h00000013, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0};

        rst_n          = 1'b0;
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.fetch_addr = 32'h1C;
        modelErr       = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("inReset");
        rst_n = 1'b1;
        @(negedge clk);
        checkResetValues("afterRelease");

        // Cycle-exact table: two-word load, ignored inputs in RUN, reload, ignored start in LOAD.
        writeLog.delete();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkBit($sformatf("vec%0d.byteReady", i), bus.byte_ready, vecs[i].expReady);
            checkBit($sformatf("vec%0d.memWe", i), bus.mem_we, vecs[i].expWe);
            checkOutput($sformatf("vec%0d.memWaddr", i), bus.mem_waddr, vecs[i].expWaddr);
            checkOutput($sformatf("vec%0d.memWdata", i), bus.mem_wdata, vecs[i].expWdata);
            checkOutput($sformatf("vec%0d.memRaddr", i), bus.mem_raddr, vecs[i].expRaddr);
            checkBit($sformatf("vec%0d.cpuRstN", i), bus.cpu_rst_n, vecs[i].expCpuRstN);
            checkBit($sformatf("vec%0d.busy", i), bus.busy, vecs[i].expBusy);
            checkBit($sformatf("vec%0d.done", i), bus.done, vecs[i].expDone);
            checkBit($sformatf("vec%0d.err", i), bus.err, vecs[i].expErr);
        end
        bus.load_start = 1'b0;
        bus.byte_valid = 1'b0;
        checkOutput("tableWriteCount", 32'(writeLog.size()), 32'd3);
        if (writeLog.size() == 3) begin
            checkOutput("tableWrite0", writeLog[0][31:0], 32'h00100193);
            checkOutput("tableWrite1Addr", writeLog[1][63:32], 32'h4);
            checkOutput("tableWrite2", writeLog[2][31:0], 32'h00000013);
        end

        // Same program with byte_valid toggling.
        writeLog.delete();
        progBytes = '{8'h93, 8'h01, 8'h10, 8'h00, 8'h33, 8'h82, 8'h20, 8'h00};
        startLoad(9'd2);
        streamProgram(1);

        // Oversized length: error, no load; then a valid load clears the flag.
        writeLog.delete();
        startLoad(9'd257);
        bus.fetch_addr = 32'h1C;
        for (int i = 0; i < 4; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'(i + 8'hA0);
            @(negedge clk);
            checkBit($sformatf("errIdle%0d.byteReady", i), bus.byte_ready, 1'b0);
            checkBit($sformatf("errIdle%0d.err", i), bus.err, 1'b1);
            checkOutput($sformatf("errIdle%0d.memRaddr", i), bus.mem_raddr, 32'h0);
        end
        bus.byte_valid = 1'b0;
        checkOutput("errWriteCount", 32'(writeLog.size()), 32'd0);
        progBytes = '{8'h13, 8'h05, 8'h50, 8'h00};
        startLoad(9'd1);
        streamProgram(0);

        // Asynchronous reset part-way through a two-word load, then a fresh load.
        writeLog.delete();
        startLoad(9'd2);
        progBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) sendByte(progBytes[i]);
        #2 rst_n = 1'b0;
        #1 checkResetValues("midLoadReset");
        modelErr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        writeLog.delete();
        progBytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        startLoad(9'd2);
        streamProgram(0);

        // Zero-length load goes straight to RUN; a reload from RUN drops the CPU reset.
        writeLog.delete();
        startLoad(9'd0);
        repeat (3) @(negedge clk);
        checkOutput("zeroLenWriteCount", 32'(writeLog.size()), 32'd0);
        bus.fetch_addr = 32'h1C;
        #1 checkOutput("runRaddr", bus.mem_raddr, 32'h1C);
        progBytes = '{8'h6F, 8'h00, 8'h00, 8'h00};
        startLoad(9'd1);
        streamProgram(0);

        // Largest legal load fills every word.
        writeLog.delete();
        progBytes.delete();
        for (int i = 0; i < 4 * DEPTH; i++) progBytes.push_back(8'($urandom));
        startLoad(9'(DEPTH));
        streamProgram(0);

        // Randomized loads against the word-list model.
        for (int r = 0; r < 40; r++) begin
            writeLog.delete();
            sel = $urandom_range(0, 9);
            if (sel == 0) len = 9'd0;
            else if (sel == 1) len = 9'(257 + $urandom_range(0, 254));
            else len = 9'($urandom_range(1, 4));
            startLoad(len);
            if (len != 0 && int'(len) <= DEPTH) begin
                progBytes.delete();
                for (int i = 0; i < 4 * int'(len); i++) progBytes.push_back(8'($urandom));
                streamProgram(2);
            end else begin
                bus.byte_valid = 1'b1;
                bus.byte_data  = 8'($urandom);
                repeat (2) @(negedge clk);
                checkBit($sformatf("rnd%0d.byteReady", r), bus.byte_ready, 1'b0);
                bus.byte_valid = 1'b0;
                checkOutput($sformatf("rnd%0d.writeCount", r), 32'(writeLog.size()), 32'd0);
            end
            fa = $urandom;
            bus.fetch_addr = fa;
            #1 checkOutput($sformatf("rnd%0d.memRaddr", r), bus.mem_raddr, (len == 0 || int'(len) <= DEPTH) ? fa : 32'h0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/imem_boot_ctrl.md
Name: imem_boot_ctrl

Overview:
Boot sequencer for the 256-word instruction memory of the single-cycle RISC-V core. It holds the CPU in reset and accepts a little-endian byte stream from the host/UART side. It assembles 32-bit words, writes them into instruction memory through a write port, then releases the CPU. After boot it passes the CPU fetch address through to the memory read port.

Parameters:
DEPTH, 256, number of 32-bit words in instruction memory.
IDX_W, 8, word-index width; equals log2(DEPTH).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
load_start  input  1  single-cycle request to begin a program load.
load_len  input  IDX_W+1  number of words to load; sampled when load_start is accepted.
byte_valid  input  1  byte_data is valid this cycle.
byte_data  input  8  program byte; stream order is word 0 byte 0 first.
byte_ready  output  1  block accepts a byte this cycle.
mem_we  output  1  instruction-memory write strobe, one cycle per word.
mem_waddr  output  32  byte address of the word being written (word_idx<<2).
mem_wdata  output  32  assembled instruction word.
fetch_addr  input  32  CPU PC / fetch byte address.
mem_raddr  output  32  address driven to the instruction-memory read port.
cpu_rst_n  output  1  active-low reset to the CPU core.
busy  output  1  high while in LOAD.
done  output  1  high while in RUN.
err  output  1  sticky flag: load_len exceeded DEPTH.

Behaviour:
- Reset is asynchronous, active-low.
  - FSM goes to IDLE; byte counter, word index and the assembly register are cleared.
  - Output values in reset: byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0.
- States: IDLE, LOAD, RUN.
- IDLE:
  - cpu_rst_n=0 and byte_ready=0.
  - On load_start, sample load_len:
    - load_len=0: go to RUN.
    - load_len>DEPTH: set err=1 and stay in IDLE.
    - Otherwise: clear err, go to LOAD.
- LOAD:
  - busy=1 and byte_ready=1.
  - A byte is accepted when byte_valid && byte_ready.
  - Byte k of a word (k=0..3) lands in bits [8k+7:8k].
  - On acceptance of byte 3, the completed word is copied into the mem_wdata register and mem_waddr={word_idx,2'b00}. mem_we=1 in the following cycle, for exactly one cycle.
  - word_idx increments with each write. The assembly register is free in the same cycle, so back-to-back bytes incur no stall.
  - In the cycle after the mem_we for word load_len-1, the FSM enters RUN.
  - load_start is ignored while in LOAD.
- RUN:
  - done=1, cpu_rst_n=1 (registered, so it first rises one cycle after the final mem_we) and byte_ready=0.
  - load_start causes a reload: cpu_rst_n drops to 0 on the next edge, and the FSM enters LOAD (or RUN/IDLE according to the same load_len rules as in IDLE).
- mem_raddr is combinational: fetch_addr in RUN, 32'h0 otherwise.
- Bytes presented outside LOAD are not accepted (byte_ready=0); nothing is written.
- mem_we is never asserted outside LOAD, or in the cycle immediately after the final word.
- Reset during LOAD: the partial word is discarded. The memory contents already written are not cleared; a new load overwrites them from word 0.
- word_idx never wraps, because load_len is capped at DEPTH by the err check.

Test Plan:
- Reset, then load_start with load_len=2 and bytes 93,01,10,00,33,82,20,00 streamed back-to-back -> mem_we pulses with (waddr 0x0, wdata 0x00100193) and (waddr 0x4, wdata 0x00208233); cpu_rst_n=1 and done=1 one cycle after the second pulse.
- Same load with byte_valid toggling 1,0,1,0 -> identical write values; mem_we pulses only after each 4th accepted byte.
- load_start with load_len=257 -> err=1, state stays IDLE, byte_ready=0, no writes; a subsequent valid load (load_len=1) clears err and completes.
- In RUN, fetch_addr=0x1C -> mem_raddr=0x1C same cycle; in IDLE/LOAD, mem_raddr=0.
- rst_n asserted after 6 bytes of a 2-word load -> all outputs return to reset values immediately; a restarted load writes word 0 at waddr 0x0 with fresh data.
- load_start with load_len=0 -> RUN the next cycle, cpu_rst_n=1, no mem_we; load_start in RUN with load_len=1 -> cpu_rst_n=0 next cycle, busy=1.
